// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one req/ack bus transaction per
// load/store held in EX/MEM, stalls the upstream pipeline, and extends load results.
module mem_access_unit #(
  parameter int datawidth   = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [datawidth-1:0] ALU_in,
  input  logic [datawidth-1:0] datareg_in,
  input  logic [1:0]           WBsel_in,
  input  logic                 MEMRw_in,
  input  logic [2:0]           Rsel_in,
  input  logic [1:0]           Wsel_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [datawidth-1:0] dmem_addr,
  output logic [datawidth-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ack,
  input  logic [datawidth-1:0] dmem_rdata,
  output logic                 mem_stall,
  output logic [datawidth-1:0] load_data,
  output logic                 load_valid,
  output logic                 misalign_err,
  output logic                 bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        is_load_q;

  logic        is_store, is_load, is_op;
  logic [1:0]  size;
  logic        uns;
  logic        size_ok, aligned, legal, misaligned;
  logic [3:0]  be;
  logic [31:0] wdata;

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] off,
                                          input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      2'd0:    r = {{24{~u & b[7]}}, b};
      2'd1:    r = {{16{~u & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign is_store = MEMRw_in;
  assign is_load  = ~MEMRw_in & (WBsel_in == 2'b01);
  assign is_op    = is_store | is_load;

  // Decode access size and legality, and build store lanes.
  always_comb begin
    size    = 2'd0;
    uns     = 1'b0;
    size_ok = 1'b0;
    if (is_store) begin
      case (Wsel_in)
        2'b00:   begin size = 2'd0; size_ok = 1'b1; end
        2'b01:   begin size = 2'd1; size_ok = 1'b1; end
        2'b10:   begin size = 2'd2; size_ok = 1'b1; end
        default: size_ok = 1'b0;
      endcase
    end else begin
      case (Rsel_in)
        3'b000:  begin size = 2'd0; size_ok = 1'b1; end
        3'b001:  begin size = 2'd1; size_ok = 1'b1; end
        3'b010:  begin size = 2'd2; size_ok = 1'b1; end
        3'b100:  begin size = 2'd0; uns = 1'b1; size_ok = 1'b1; end
        3'b101:  begin size = 2'd1; uns = 1'b1; size_ok = 1'b1; end
        default: size_ok = 1'b0;
      endcase
    end
    case (size)
      2'd1:    aligned = ~ALU_in[0];
      2'd2:    aligned = (ALU_in[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal      = is_op & size_ok & aligned;
    misaligned = is_op & ~(size_ok & aligned);
    case (size)
      2'd0:    be = 4'b0001 << ALU_in[1:0];
      2'd1:    be = 4'b0011 << ALU_in[1:0];
      default: be = 4'b1111;
    endcase
    if (!is_store) begin
      wdata = 32'h0000_0000;
    end else begin
      case (size)
        2'd0:    wdata = {4{datareg_in[7:0]}};
        2'd1:    wdata = {2{datareg_in[15:0]}};
        default: wdata = datareg_in;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; DONE always returns to IDLE so the held op is not reissued.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (legal) next_state = BUSY;
      BUSY:    if (dmem_ack || wait_cnt == TIMEOUT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stall covers the accept cycle and every BUSY cycle; forced low in reset.
  assign mem_stall = ~rst & (((state == IDLE) & legal) | (state == BUSY));

  // Bus fields, wait counter, load result and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= 4'b0000;
      wait_cnt     <= 8'd0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      is_load_q    <= 1'b0;
      load_data    <= '0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ALU_in[31:2], 2'b00};
            dmem_wdata <= wdata;
            dmem_be    <= be;
            off_q      <= ALU_in[1:0];
            size_q     <= size;
            uns_q      <= uns;
            is_load_q  <= is_load;
            wait_cnt   <= 8'd0;
          end else if (misaligned) begin
            misalign_err <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (is_load_q) begin
              load_data  <= extract(dmem_rdata, off_q, size_q, uns_q);
              load_valid <= 1'b1;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-op vectors with a zero-wait bus,
// plus hand-written sequences for late ack, ack timeout and reset mid-transaction.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_in, datareg_in, dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [1:0]  WBsel_in, Wsel_in;
  logic        MEMRw_in, dmem_req, dmem_we, dmem_ack, mem_stall, load_valid;
  logic        misalign_err, bus_err;
  logic [2:0]  Rsel_in;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.datawidth(32), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ALU_in(ALU_in), .datareg_in(datareg_in),
    .WBsel_in(WBsel_in), .MEMRw_in(MEMRw_in), .Rsel_in(Rsel_in), .Wsel_in(Wsel_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .load_data(load_data),
    .load_valid(load_valid), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  // kind: 0 = no-op, 1 = legal access, 2 = misaligned/illegal
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  wbsel;
    logic        memrw;
    logic [2:0]  rsel;
    logic [1:0]  wsel;
    logic [31:0] rdata;
    int          kind;
    logic        we;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebe;
    logic        isld;
    logic [31:0] eload;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] wb,
                        input logic rw, input logic [2:0] rs, input logic [1:0] ws);
    ALU_in = a; datareg_in = d; WBsel_in = wb; MEMRw_in = rw; Rsel_in = rs; Wsel_in = ws;
  endtask

  task automatic noop();
    set_op(32'h0, 32'h0, 2'b00, 1'b0, 3'b000, 2'b00);
  endtask

  initial begin
    logic [31:0] exp_ld;
    int stall_cnt;

    vt[0]  = '{32'h1000_0008, 32'hDEAD_BEEF, 2'b00, 1'b1, 3'b000, 2'b10, 32'h0, 1,
               1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0};
    vt[1]  = '{32'h0000_0103, 32'h0, 2'b01, 1'b0, 3'b000, 2'b00, 32'h80FF_1234, 1,
               1'b0, 32'h0000_0100, 32'h0, 4'b1000, 1'b1, 32'hFFFF_FF80};
    vt[2]  = '{32'h0000_0103, 32'h0, 2'b01, 1'b0, 3'b100, 2'b00, 32'h80FF_1234, 1,
               1'b0, 32'h0000_0100, 32'h0, 4'b1000, 1'b1, 32'h0000_0080};
    vt[3]  = '{32'h0000_0202, 32'h0, 2'b01, 1'b0, 3'b001, 2'b00, 32'h8001_7FFF, 1,
               1'b0, 32'h0000_0200, 32'h0, 4'b1100, 1'b1, 32'hFFFF_8001};
    vt[4]  = '{32'h0000_0200, 32'h0, 2'b01, 1'b0, 3'b101, 2'b00, 32'h1234_F00D, 1,
               1'b0, 32'h0000_0200, 32'h0, 4'b0011, 1'b1, 32'h0000_F00D};
    vt[5]  = '{32'h0000_0304, 32'h0, 2'b01, 1'b0, 3'b010, 2'b00, 32'hCAFE_BABE, 1,
               1'b0, 32'h0000_0304, 32'h0, 4'b1111, 1'b1, 32'hCAFE_BABE};
    vt[6]  = '{32'h0000_0401, 32'h1234_56AB, 2'b00, 1'b1, 3'b000, 2'b00, 32'h0, 1,
               1'b1, 32'h0000_0400, 32'hABAB_ABAB, 4'b0010, 1'b0, 32'h0};
    vt[7]  = '{32'h0000_0010, 32'hFFFF_1357, 2'b00, 1'b1, 3'b000, 2'b01, 32'h0, 1,
               1'b1, 32'h0000_0010, 32'h1357_1357, 4'b0011, 1'b0, 32'h0};
    vt[8]  = '{32'h0000_0020, 32'h1122_3344, 2'b01, 1'b1, 3'b000, 2'b10, 32'h0, 1,
               1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 1'b0, 32'h0};
    vt[9]  = '{32'h0000_0006, 32'h0, 2'b01, 1'b0, 3'b010, 2'b00, 32'h0, 2,
               1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0};
    vt[10] = '{32'h0000_0101, 32'h0, 2'b01, 1'b0, 3'b001, 2'b00, 32'h0, 2,
               1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0};
    vt[11] = '{32'h0000_0002, 32'h5555_5555, 2'b00, 1'b1, 3'b000, 2'b10, 32'h0, 2,
               1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0};
    vt[12] = '{32'h0000_0000, 32'h0, 2'b01, 1'b0, 3'b011, 2'b00, 32'h0, 2,
               1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0};
    vt[13] = '{32'h0000_0000, 32'h0, 2'b00, 1'b1, 3'b000, 2'b11, 32'h0, 2,
               1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0};
    vt[14] = '{32'h0000_0100, 32'h0, 2'b10, 1'b0, 3'b000, 2'b00, 32'h0, 0,
               1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0};
    vt[15] = '{32'h0000_0101, 32'h0, 2'b01, 1'b0, 3'b000, 2'b00, 32'h80FF_1234, 1,
               1'b0, 32'h0000_0100, 32'h0, 4'b0010, 1'b1, 32'h0000_0012};

    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0; exp_ld = 32'h0;
    noop();
    repeat (2) step();
    smp();
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_flags", {29'h0, load_valid, misalign_err, bus_err}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Table vectors; each legal op is followed directly by the next (3-cycle period).
    for (int v = 0; v < 16; v++) begin
      set_op(vt[v].addr, vt[v].data, vt[v].wbsel, vt[v].memrw, vt[v].rsel, vt[v].wsel);
      dmem_ack = 1'b0;
      smp();
      chk($sformatf("v%0d_stray_mis", v), {31'h0, misalign_err}, 32'h0);
      chk($sformatf("v%0d_accept_stall", v), {31'h0, mem_stall}, {31'h0, vt[v].kind == 1});
      step();
      if (vt[v].kind == 1) begin
        dmem_rdata = vt[v].rdata;
        dmem_ack = 1'b1;
        smp();
        chk($sformatf("v%0d_req", v), {31'h0, dmem_req}, 32'h1);
        chk($sformatf("v%0d_we", v), {31'h0, dmem_we}, {31'h0, vt[v].we});
        chk($sformatf("v%0d_addr", v), dmem_addr, vt[v].eaddr);
        chk($sformatf("v%0d_wdata", v), dmem_wdata, vt[v].ewdata);
        chk($sformatf("v%0d_be", v), {28'h0, dmem_be}, {28'h0, vt[v].ebe});
        chk($sformatf("v%0d_busy_stall", v), {31'h0, mem_stall}, 32'h1);
        step();
        dmem_ack = 1'b0;
        smp();
        chk($sformatf("v%0d_done_req", v), {31'h0, dmem_req}, 32'h0);
        chk($sformatf("v%0d_done_stall", v), {31'h0, mem_stall}, 32'h0);
        chk($sformatf("v%0d_load_valid", v), {31'h0, load_valid}, {31'h0, vt[v].isld});
        if (vt[v].isld) exp_ld = vt[v].eload;
        chk($sformatf("v%0d_load_data", v), load_data, exp_ld);
        step();
      end else if (vt[v].kind == 2) begin
        noop();
        smp();
        chk($sformatf("v%0d_mis", v), {31'h0, misalign_err}, 32'h1);
        chk($sformatf("v%0d_mis_req", v), {31'h0, dmem_req}, 32'h0);
        chk($sformatf("v%0d_mis_stall", v), {31'h0, mem_stall}, 32'h0);
        step();
      end else begin
        smp();
        chk($sformatf("v%0d_noop_req", v), {31'h0, dmem_req}, 32'h0);
        chk($sformatf("v%0d_noop_mis", v), {31'h0, misalign_err}, 32'h0);
        chk($sformatf("v%0d_noop_stall", v), {31'h0, mem_stall}, 32'h0);
        step();
      end
    end
    noop();
    step();

    // SH with ack on the 4th BUSY cycle: 5 stall cycles, bus fields stable.
    set_op(32'h0000_0002, 32'h0000_A5C3, 2'b00, 1'b1, 3'b000, 2'b01);
    dmem_ack = 1'b0;
    stall_cnt = 0;
    smp();
    if (mem_stall) stall_cnt++;
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) dmem_ack = 1'b1;
      smp();
      chk($sformatf("sh_addr_%0d", i), dmem_addr, 32'h0000_0000);
      chk($sformatf("sh_wdata_%0d", i), dmem_wdata, 32'hA5C3_A5C3);
      chk($sformatf("sh_be_%0d", i), {28'h0, dmem_be}, 32'hC);
      chk($sformatf("sh_req_%0d", i), {31'h0, dmem_req}, 32'h1);
      if (mem_stall) stall_cnt++;
      step();
    end
    dmem_ack = 1'b0;
    smp();
    chk("sh_done_stall", {31'h0, mem_stall}, 32'h0);
    chk("sh_done_req", {31'h0, dmem_req}, 32'h0);
    chk("sh_bus_err", {31'h0, bus_err}, 32'h0);
    chk("sh_stall_cycles", stall_cnt, 32'd5);
    noop();
    step();

    // LW with no ack: timeout after 4 BUSY cycles, load_data unchanged.
    set_op(32'h0000_0040, 32'h0, 2'b01, 1'b0, 3'b010, 2'b00);
    dmem_rdata = 32'h7777_7777;
    step();
    for (int i = 1; i <= 4; i++) begin
      smp();
      chk($sformatf("to_req_%0d", i), {31'h0, dmem_req}, 32'h1);
      chk($sformatf("to_bus_err_%0d", i), {31'h0, bus_err}, 32'h0);
      step();
    end
    smp();
    chk("to_bus_err", {31'h0, bus_err}, 32'h1);
    chk("to_done_req", {31'h0, dmem_req}, 32'h0);
    chk("to_done_stall", {31'h0, mem_stall}, 32'h0);
    chk("to_load_valid", {31'h0, load_valid}, 32'h0);
    chk("to_load_data", load_data, exp_ld);
    noop();
    step();
    smp();
    chk("to_idle_bus_err", {31'h0, bus_err}, 32'h0);
    chk("to_idle_req", {31'h0, dmem_req}, 32'h0);
    step();

    // Reset while BUSY: req drops without a clock edge; a later ack is ignored.
    set_op(32'h0000_0080, 32'h0, 2'b01, 1'b0, 3'b010, 2'b00);
    step();
    smp();
    chk("rb_req_before", {31'h0, dmem_req}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rb_req_async", {31'h0, dmem_req}, 32'h0);
    chk("rb_stall", {31'h0, mem_stall}, 32'h0);
    chk("rb_addr", dmem_addr, 32'h0);
    chk("rb_load_data", load_data, 32'h0);
    noop();
    step();
    rst = 1'b0;
    dmem_rdata = 32'hFFFF_FFFF;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    smp();
    chk("rb_late_ack_valid", {31'h0, load_valid}, 32'h0);
    chk("rb_late_ack_req", {31'h0, dmem_req}, 32'h0);
    chk("rb_late_ack_data", load_data, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
